spsram_req_ctrl: RTL

//   Initiator-side front end for the single-port SRAM wrappers (512x32 class).

---
 rtl/spsram_req_ctrl.sv | 92 +++++++++
 1 files changed

// File: rtl/spsram_req_ctrl.sv
// Request front end for a single-port SRAM: issues reads/writes, tracks reads across
// the fixed SRAM latency and returns read data through a credit-guarded FWFT FIFO.
module spsram_req_ctrl #(
  parameter int ADDR_W     = 9,
  parameter int DATA_W     = 32,
  parameter int RD_LATENCY = 2,
  parameter int RSP_DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              busy
);

  localparam int CNT_W = $clog2(RSP_DEPTH + 1);
  localparam int PTR_W = $clog2(RSP_DEPTH);

  logic [RD_LATENCY-1:0] rd_vld_p;
  logic [CNT_W-1:0]      inflight;
  logic [CNT_W-1:0]      fifo_count;
  logic [CNT_W-1:0]      credits;
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [DATA_W-1:0]     fifo_mem [RSP_DEPTH];
  logic                  ready_en;
  logic                  accept;
  logic                  rd_accept;
  logic                  push;
  logic                  pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Every read accepted holds a FIFO slot from issue until it is popped.
  assign credits   = CNT_W'(RSP_DEPTH) - inflight - fifo_count;
  assign req_ready = ~rst & ready_en & (credits != '0);
  assign accept    = req_valid & req_ready;
  assign rd_accept = accept & ~req_we;

  assign mem_en   = accept;
  assign mem_we   = accept & req_we;
  assign mem_addr = req_addr;
  assign mem_din  = req_wdata;

  assign push      = rd_vld_p[RD_LATENCY-1];
  assign rsp_valid = ~rst & (fifo_count != '0);
  assign pop       = rsp_valid & rsp_ready;
  assign rsp_rdata = fifo_mem[rd_ptr];
  assign busy      = ~rst & ((inflight != '0) | (fifo_count != '0));

  // Stage boundary: read tag pipe aligned with SRAM latency, plus FIFO control.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_vld_p   <= '0;
      inflight   <= '0;
      fifo_count <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      ready_en   <= 1'b0;
    end else begin
      ready_en    <= 1'b1;
      rd_vld_p[0] <= rd_accept;
      for (int i = 1; i < RD_LATENCY; i++) begin
        rd_vld_p[i] <= rd_vld_p[i-1];
      end
      inflight   <= inflight + CNT_W'(rd_accept) - CNT_W'(push);
      fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      assert (!push || fifo_count != CNT_W'(RSP_DEPTH));
    end
  end

  // Stage boundary: read data captured as its tag leaves the pipe.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= mem_dout;
  end

endmodule
